// File: rtl/demux_b3_stream_if.sv
// Stream bundle for the 1-to-3 binary-select demux:
// one input stream, three output channels and the drop status.
interface demux_b3_stream_if #(
    parameter int K     = 4,
    parameter int CNT_W = 8
);
    logic [K-1:0]     in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [K-1:0]     out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [K-1:0]     out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [K-1:0]     out2_data;
    logic             out2_valid;
    logic             out2_ready;

    logic             drop_err;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output in_data, in_sel, in_valid,
        output out0_ready, out1_ready, out2_ready,
        input  in_ready,
        input  out0_data, out0_valid,
        input  out1_data, out1_valid,
        input  out2_data, out2_valid,
        input  drop_err, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid,
        input  out0_ready, out1_ready, out2_ready,
        output in_ready,
        output out0_data, out0_valid,
        output out1_data, out1_valid,
        output out2_data, out2_valid,
        output drop_err, drop_cnt
    );
endinterface

// File: rtl/demux_b3_stream.sv
// Registered 1-to-3 stream demux with binary select; each channel is a
// 1-entry valid/ready slot, select 3 is consumed, dropped and counted.
module demux_b3_stream #(
    parameter int K     = 4,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               reset,
    demux_b3_stream_if.slave  bus
);
    logic [K-1:0]     data_q [3];
    logic [2:0]       valid_q;
    logic [2:0]       rdy_vec;
    logic [2:0]       hit;
    logic             in_ready;
    logic             accept;
    logic             drop;
    logic             drop_err_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // Ready depends only on the addressed slot; other slots never stall input.
    always_comb begin
        rdy_vec  = {bus.out2_ready, bus.out1_ready, bus.out0_ready};
        hit      = 3'b000;
        in_ready = 1'b1;
        unique case (bus.in_sel)
            2'd0: begin
                hit[0]   = 1'b1;
                in_ready = !valid_q[0] | rdy_vec[0];
            end
            2'd1: begin
                hit[1]   = 1'b1;
                in_ready = !valid_q[1] | rdy_vec[1];
            end
            2'd2: begin
                hit[2]   = 1'b1;
                in_ready = !valid_q[2] | rdy_vec[2];
            end
            default: begin
                hit      = 3'b000;
                in_ready = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid & in_ready;
    assign drop   = accept & (bus.in_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (accept && hit[n]) begin
                    data_q[n]  <= bus.in_data;
                    valid_q[n] <= 1'b1;
                end else if (valid_q[n] && rdy_vec[n]) begin
                    valid_q[n] <= 1'b0;
                end
            end
        end
    end

    // Counter sticks at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_err_q <= drop;
            if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_data  = data_q[0];
    assign bus.out0_valid = valid_q[0];
    assign bus.out1_data  = data_q[1];
    assign bus.out1_valid = valid_q[1];
    assign bus.out2_data  = data_q[2];
    assign bus.out2_valid = valid_q[2];
    assign bus.drop_err   = drop_err_q;
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_demux_b3_stream.sv
// Randomized + directed bench for demux_b3_stream against a queue-based
// model of three one-deep channels and a saturating drop tally.
module tb_demux_b3_stream;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux_b3_stream_if #(.K(4), .CNT_W(8)) bus ();

    demux_b3_stream #(.K(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    bit [3:0] q [3][$];
    bit [3:0] last [3];
    int       m_cnt;
    bit       m_err;
    bit       stalled;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input bit [1:0] s, input bit [3:0] d,
                       input bit r0, input bit r1, input bit r2);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
    endtask

    // Check outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        bit [2:0] rdy;
        bit [3:0] d;
        bit       exp_rdy;
        bit       acc;
        int       s;
        @(negedge clk);
        rdy = {bus.out2_ready, bus.out1_ready, bus.out0_ready};
        s = int'(bus.in_sel);
        d = bus.in_data;
        exp_rdy = (s == 3) || (q[s].size() == 0) || rdy[s];
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        chk("out0_valid", {31'b0, bus.out0_valid}, {31'b0, q[0].size() != 0});
        chk("out1_valid", {31'b0, bus.out1_valid}, {31'b0, q[1].size() != 0});
        chk("out2_valid", {31'b0, bus.out2_valid}, {31'b0, q[2].size() != 0});
        chk("out0_data", {28'b0, bus.out0_data}, {28'b0, last[0]});
        chk("out1_data", {28'b0, bus.out1_data}, {28'b0, last[1]});
        chk("out2_data", {28'b0, bus.out2_data}, {28'b0, last[2]});
        chk("drop_err", {31'b0, bus.drop_err}, {31'b0, m_err});
        chk("drop_cnt", {24'b0, bus.drop_cnt}, m_cnt);
        acc = bus.in_valid && exp_rdy;
        stalled = bus.in_valid && !exp_rdy;
        @(posedge clk);
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                q[n].delete();
                last[n] = 4'd0;
            end
            m_cnt = 0;
            m_err = 1'b0;
            stalled = 1'b0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (q[n].size() != 0 && rdy[n]) void'(q[n].pop_front());
                if (acc && s == n) begin
                    q[n].push_back(d);
                    last[n] = d;
                end
            end
            m_err = acc && (s == 3);
            if (m_err && m_cnt < 255) m_cnt++;
        end
        #1;
    endtask

    initial begin
        m_cnt = 0;
        m_err = 1'b0;
        stalled = 1'b0;
        for (int n = 0; n < 3; n++) last[n] = 4'd0;

        // Reset held two cycles with a valid word pending.
        reset = 1'b1;
        drv(1'b1, 2'd0, 4'hA, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        drv(1'b0, 2'd0, 4'hA, 1'b1, 1'b1, 1'b1);
        tick();
        tick();

        // Routing 1,2,4 to channels 0,1,2.
        drv(1'b1, 2'd0, 4'd1, 1'b1, 1'b1, 1'b1);
        tick();
        drv(1'b1, 2'd1, 4'd2, 1'b1, 1'b1, 1'b1);
        tick();
        drv(1'b1, 2'd2, 4'd4, 1'b1, 1'b1, 1'b1);
        tick();
        drv(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();

        // Backpressure on channel 1.
        drv(1'b1, 2'd1, 4'd5, 1'b1, 1'b0, 1'b1);
        tick();
        drv(1'b1, 2'd1, 4'd6, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        chk("t3_stall", {31'b0, bus.in_ready}, 32'd0);
        chk("t3_hold", {28'b0, bus.out1_data}, 32'd5);
        bus.out1_ready = 1'b1;
        tick();
        drv(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("t3_new", {28'b0, bus.out1_data}, 32'd6);
        tick();

        // Full-rate stream on channel 0.
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 2'd0, 4'(i), 1'b1, 1'b1, 1'b1);
            tick();
        end
        drv(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();

        // Invalid select, then saturation.
        drv(1'b1, 2'd3, 4'd9, 1'b1, 1'b1, 1'b1);
        tick();
        drv(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("t5_pulse", {31'b0, bus.drop_err}, 32'd1);
        chk("t5_cnt1", {24'b0, bus.drop_cnt}, 32'd1);
        tick();
        drv(1'b1, 2'd3, 4'd9, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) tick();
        drv(1'b0, 2'd0, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t5_sat", {24'b0, bus.drop_cnt}, 32'd255);

        // Drain and refill channel 2 in one cycle; reset with ch0 full.
        drv(1'b1, 2'd2, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        drv(1'b1, 2'd2, 4'd7, 1'b1, 1'b1, 1'b1);
        tick();
        drv(1'b1, 2'd0, 4'd8, 1'b0, 1'b1, 1'b0);
        chk("t6_v2", {31'b0, bus.out2_valid}, 32'd1);
        chk("t6_d2", {28'b0, bus.out2_data}, 32'd7);
        tick();
        drv(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst", {31'b0, bus.out0_valid}, 32'd0);
        tick();

        // Random traffic with legal source stalls and rare resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            bus.out0_ready = ($urandom_range(0, 9) < 7);
            bus.out1_ready = ($urandom_range(0, 9) < 5);
            bus.out2_ready = ($urandom_range(0, 9) < 8);
            if (!stalled) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 4'($urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
